// File: rtl/alu_pkg.sv
// alu_pkg: widths, idle opcode and sweep states shared by the alu sweep sequencer.
package alu_pkg;
  localparam int CARD_W = 5;
  localparam int DATA_W = 32;
  localparam logic [CARD_W-1:0] CARD_IDLE = 5'd0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_sweep_collect.sv
// alu_sweep_collect: accumulates the F signature and per-opcode Cout/Zero masks.
module alu_sweep_collect
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [CARD_W-1:0] idx,
  input  logic [DATA_W-1:0] f,
  input  logic              cout,
  input  logic              zero,
  output logic [DATA_W-1:0] sig,
  output logic [N-1:0]      cout_mask,
  output logic [N-1:0]      zero_mask
);
  // masks are cleared at sweep start and each bit is written once, so OR-in suffices
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig       <= '0;
      cout_mask <= '0;
      zero_mask <= '0;
    end else if (en) begin
      sig       <= sig + f;
      cout_mask <= cout_mask | (N'(cout) << idx);
      zero_mask <= zero_mask | (N'(zero) << idx);
    end
  end
endmodule

// File: rtl/alu_sweep_seq.sv
// alu_sweep_seq: sweeps alu opcodes OP_FIRST..OP_LAST on one latched operand set and collects results.
module alu_sweep_seq
  import alu_pkg::*;
#(
  parameter int OP_FIRST = 1,
  parameter int OP_LAST  = 16,
  parameter int SETTLE   = 0,
  localparam int N = OP_LAST - OP_FIRST + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              cin_in,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [CARD_W-1:0] alu_card,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_cout,
  input  logic              alu_zero,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sig,
  output logic [N-1:0]      cout_mask,
  output logic [N-1:0]      zero_mask
);
  localparam int CW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SET_C = CW'(SETTLE);
  localparam logic [CARD_W-1:0] FIRST_C = CARD_W'(OP_FIRST);
  localparam logic [CARD_W-1:0] LAST_C = CARD_W'(OP_LAST);
  state_t state, state_n;
  logic [CARD_W-1:0] card_n;
  logic [CW-1:0] cnt, cnt_n;
  logic latch, sample;
  always_comb begin
    state_n = state;
    card_n  = alu_card;
    cnt_n   = cnt;
    latch   = 1'b0;
    sample  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        card_n  = FIRST_C;
        cnt_n   = '0;
        latch   = 1'b1;
      end
      RUN: if (cnt != SET_C) cnt_n = cnt + 1'b1;
      else begin
        sample  = 1'b1;
        state_n = alu_card == LAST_C ? DONE : RUN;
        card_n  = alu_card == LAST_C ? CARD_IDLE : alu_card + 1'b1;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      alu_card <= CARD_IDLE;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
    end else begin
      state    <= state_n;
      alu_card <= card_n;
      cnt      <= cnt_n;
      if (latch) begin
        alu_a   <= a_in;
        alu_b   <= b_in;
        alu_cin <= cin_in;
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  alu_sweep_collect #(.N(N)) u_collect (
    .clk       (clk),
    .rst       (rst),
    .clr       (latch),
    .en        (sample),
    .idx       (alu_card - FIRST_C),
    .f         (alu_f),
    .cout      (alu_cout),
    .zero      (alu_zero),
    .sig       (sig),
    .cout_mask (cout_mask),
    .zero_mask (zero_mask)
  );
endmodule

// File: tb/tb_alu_sweep_seq.sv
// tb_alu_sweep_seq: checks two sequencer instances (SETTLE 0 and 2) against a stub-ALU sweep model.
module tb_alu_sweep_seq;
  import alu_pkg::*;
  localparam int OF = 1;
  localparam int OL = 16;
  localparam int N = OL - OF + 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] start_v;
  logic [31:0] a_in, b_in;
  logic cin_in;
  logic [31:0] aa[2], ab[2], af[2], sg[2];
  logic ac[2], co[2], zo[2], bz[2], dn[2];
  logic [4:0] cd[2];
  logic [N-1:0] cm[2], zm[2];
  int checks = 0;
  int errors = 0;
  assign {co[0], af[0]} = {1'b0, aa[0]} + {28'd0, cd[0]};
  assign {co[1], af[1]} = {1'b0, aa[1]} + {28'd0, cd[1]};
  assign zo[0] = af[0] == 32'd0;
  assign zo[1] = af[1] == 32'd0;
  alu_sweep_seq #(.OP_FIRST(OF), .OP_LAST(OL), .SETTLE(0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_cin(ac[0]), .alu_card(cd[0]), .alu_f(af[0]),
    .alu_cout(co[0]), .alu_zero(zo[0]), .busy(bz[0]), .done(dn[0]), .sig(sg[0]),
    .cout_mask(cm[0]), .zero_mask(zm[0]));
  alu_sweep_seq #(.OP_FIRST(OF), .OP_LAST(OL), .SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_cin(ac[1]), .alu_card(cd[1]), .alu_f(af[1]),
    .alu_cout(co[1]), .alu_zero(zo[1]), .busy(bz[1]), .done(dn[1]), .sig(sg[1]),
    .cout_mask(cm[1]), .zero_mask(zm[1]));
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic void model(input logic [31:0] a, output logic [31:0] s,
                                output logic [N-1:0] cmk, output logic [N-1:0] zmk);
    logic [32:0] t;
    s = 0; cmk = 0; zmk = 0;
    for (int c = OF; c <= OL; c++) begin
      t = {1'b0, a} + 33'(c);
      s += t[31:0];
      cmk[c-OF] = t[32];
      zmk[c-OF] = t[31:0] == 32'd0;
    end
  endfunction
  task automatic idle_zero(input int k, input string tag);
    chk({tag, "_busy"}, bz[k], 0); chk({tag, "_done"}, dn[k], 0); chk({tag, "_card"}, cd[k], 0);
    chk({tag, "_sig"}, sg[k], 0); chk({tag, "_cm"}, cm[k], 0); chk({tag, "_zm"}, zm[k], 0);
    chk({tag, "_a"}, aa[k], 0); chk({tag, "_b"}, ab[k], 0); chk({tag, "_cin"}, ac[k], 0);
  endtask
  task automatic go(input int k, input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    a_in = a; b_in = b; cin_in = cin; start_v[k] = 1'b1;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
  endtask
  task automatic watch(input int k, input int st, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input bit pulse, input bit hold);
    int last;
    bit seen;
    logic [31:0] es;
    logic [N-1:0] ec, ez;
    last = 1 + N * (st + 1);
    seen = 0;
    model(a, es, ec, ez);
    for (int cyc = 1; cyc <= last + 5 && !seen; cyc++) begin
      @(negedge clk);
      start_v[k] = hold || (pulse && cyc == 5);
      if (cyc == 1) begin
        chk("clr_sig", sg[k], 0); chk("clr_cm", cm[k], 0); chk("clr_zm", zm[k], 0);
        chk("alu_b", ab[k], b); chk("alu_cin", ac[k], cin);
      end
      if (cyc < last) begin
        chk("card", cd[k], OF + (cyc - 1) / (st + 1));
        chk("busy", bz[k], 1); chk("alu_a", aa[k], a); chk("done_early", dn[k], 0);
      end else if (dn[k]) begin
        seen = 1;
        chk("done_cycle", cyc, last);
        chk("sig", sg[k], es); chk("cout_mask", cm[k], ec); chk("zero_mask", zm[k], ez);
        chk("busy_done", bz[k], 0); chk("card_done", cd[k], 0);
      end
    end
    chk("done_seen", seen, 1);
  endtask
  initial begin
    logic [31:0] ra, rb, es;
    logic [N-1:0] ec, ez;
    rst = 1'b1; start_v = 2'b00; a_in = 0; b_in = 0; cin_in = 0;
    a_in = 32'h1234_5678; start_v = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_zero(0, "rst0"); idle_zero(1, "rst2");
    rst = 1'b0; start_v = 2'b00;
    go(0, 32'd0, 32'd0, 1'b0);
    watch(0, 0, 32'd0, 32'd0, 1'b0, 0, 0);
    chk("s1_sig", sg[0], 32'h88); chk("s1_zm", zm[0], 16'h0000); chk("s1_cm", cm[0], 16'h0000);
    @(negedge clk);
    chk("s1_done_pulse", dn[0], 0); chk("s1_sig_hold", sg[0], 32'h88);
    go(0, 32'hFFFF_FFF0, 32'h5, 1'b1);
    watch(0, 0, 32'hFFFF_FFF0, 32'h5, 1'b1, 0, 0);
    chk("s2_sig", sg[0], 32'hFFFF_FF88); chk("s2_zm", zm[0], 16'h8000); chk("s2_cm", cm[0], 16'h8000);
    go(1, 32'd0, 32'd0, 1'b0);
    watch(1, 2, 32'd0, 32'd0, 1'b0, 0, 0);
    chk("s3_sig", sg[1], 32'h88); chk("s3_zm", zm[1], 16'h0000);
    ra = $urandom;
    go(0, ra, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", bz[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_zero(0, "abort");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_done", dn[0], 0);
    end
    ra = $urandom; rb = $urandom;
    go(0, ra, rb, 1'b0);
    watch(0, 0, ra, rb, 1'b0, 0, 0);
    ra = $urandom;
    go(1, ra, 32'd1, 1'b1);
    watch(1, 2, ra, 32'd1, 1'b1, 1, 0);
    ra = 32'hFFFF_FFF8;
    model(ra, es, ec, ez);
    go(0, ra, 32'd2, 1'b0);
    start_v[0] = 1'b1;
    watch(0, 0, ra, 32'd2, 1'b0, 0, 1);
    @(negedge clk);
    chk("gap_busy", bz[0], 0); chk("gap_done", dn[0], 0); chk("gap_card", cd[0], 0);
    chk("gap_sig", sg[0], es);
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    watch(0, 0, ra, 32'd2, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ra = (i % 2) ? 32'hFFFF_FFE0 + ($urandom % 32) : $urandom;
      rb = $urandom;
      go(i % 2, ra, rb, rb[0]);
      watch(i % 2, (i % 2) * 2, ra, rb, rb[0], 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sweep_seq.md
# alu_sweep_seq

Synchronous stimulus sequencer and result collector that drives the combinational `alu` port set: A, B, Cin, the 5-bit Card opcode, F, Cout and Zero. On a start pulse it latches one operand set. It then issues every opcode from `OP_FIRST` to `OP_LAST` in order, samples F, Cout and Zero for each, and returns three results with a done pulse: an additive signature of all F values, a Cout mask and a Zero mask. It sits beside `alu` in the datapath and is used for built-in self-test and for board-level sweeps where no simulator testbench is available.

## Interface
Parameters:
- `OP_FIRST`, default 1: first Card value issued.
- `OP_LAST`, default 16: last Card value issued. Constraint: `OP_FIRST` ≤ `OP_LAST` ≤ 31.
- `SETTLE`, default 0: extra cycles each Card is held before sampling.
- `N`, derived as `OP_LAST-OP_FIRST+1`: number of operations per sweep.

Ports:
- `clk`, in, 1: the single clock. All logic runs on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: sweep request. Accepted only in IDLE.
- `a_in`, in, 32: operand A, latched when start is accepted.
- `b_in`, in, 32: operand B, latched when start is accepted.
- `cin_in`, in, 1: carry-in, latched when start is accepted.
- `alu_a`, out, 32: A driven to `alu`.
- `alu_b`, out, 32: B driven to `alu`.
- `alu_cin`, out, 1: Cin driven to `alu`.
- `alu_card`, out, 5: opcode driven to `alu`.
- `alu_f`, in, 32: F returned from `alu`.
- `alu_cout`, in, 1: Cout returned from `alu`.
- `alu_zero`, in, 1: Zero returned from `alu`.
- `busy`, out, 1: high from the cycle after start is accepted until done.
- `done`, out, 1: one-cycle pulse when the sweep completes.
- `sig`, out, 32: sum mod 2^32 of all sampled F values.
- `cout_mask`, out, N: bit i holds the Cout sampled for Card = `OP_FIRST`+i.
- `zero_mask`, out, N: bit i holds the Zero sampled for Card = `OP_FIRST`+i.

## Operation
States and transitions:
- IDLE → RUN when `start` is high. Latch `a_in`, `b_in` and `cin_in`. Clear `sig` and both masks. Set `alu_card` to `OP_FIRST` and the settle counter to 0.
- RUN, settle counter below `SETTLE`: increment the counter and hold Card.
- RUN, settle counter equal to `SETTLE` (the sample cycle):
  - `sig` ← `sig` + `alu_f`, wrapping mod 2^32 with the carry discarded.
  - Write the mask bits at index `alu_card`-`OP_FIRST`.
  - If `alu_card` = `OP_LAST`, go to DONE. Otherwise increment `alu_card` and reset the counter.
- DONE → IDLE after one cycle. `done` = 1 in DONE only. Set `alu_card` to 0 on entering DONE.

Output rules:
- `alu_a`, `alu_b` and `alu_cin` show the latched values. They are stable throughout RUN.
- Card 0 is the idle opcode and is driven at all times outside RUN.
- `sig` and the masks hold their final values until the next accepted start.
- `start` in RUN or DONE is ignored. It is not queued.
- `busy` = 1 exactly in RUN.

## Timing
- Every output resets to 0: `busy`, `done`, `sig`, both masks, `alu_a`, `alu_b`, `alu_cin`, `alu_card`. State resets to IDLE.
- Start is accepted at edge t0. Card `OP_FIRST` appears after t0.
- Each opcode occupies `SETTLE`+1 cycles, so `alu` sees each Card for that many cycles.
- F is sampled at the last edge of each opcode. With `SETTLE` = 0, the `alu` path must settle within one cycle.
- `done` is high in cycle t0 + 1 + N·(`SETTLE`+1). With the defaults that is t0+17.
- `rst` during RUN or DONE: return to IDLE on that edge, clear all outputs, and issue no `done` pulse.
- `start` and `rst` high in the same cycle: `rst` wins.
- `start` held high continuously: a new sweep starts in the IDLE cycle immediately after DONE, giving back-to-back sweeps with a one-cycle gap.

## Structure
- Shared package `alu_pkg` holds:
  - `CARD_W` = 5 and `DATA_W` = 32.
  - `CARD_IDLE` = 5'd0.
  - The state enum: IDLE, RUN, DONE.
- One sub-module is natural: `alu_sweep_collect`. It takes sample enable, index, F, Cout and Zero, and holds the `sig` accumulator and both masks with a clear input. The FSM, settle counter and Card counter stay in the top module.

## Test plan
All scenarios use a bench stub ALU with combinational behaviour F = A + Card (zero-extended), Cout = carry out of that add, Zero = (F == 0).

- Defaults, A = 0, B = 0, Cin = 0, start → Card steps 1…16, one per cycle; `done` at t0+17; `sig` = 32'h88; `zero_mask` = 16'h0000; `cout_mask` = 16'h0000.
- A = 32'hFFFF_FFF0 → at Card 16, F = 0 with carry out; `zero_mask` = 16'h8000; `cout_mask` = 16'h8000; `sig` = 32'hFFFF_FF88.
- `SETTLE` = 2 → each Card is held 3 cycles; `done` at t0+49; results identical to the first scenario.
- `rst` asserted at t0+5 → IDLE on the next edge; all outputs 0; no `done`; a following start runs a full, correct sweep.
- `start` pulsed during RUN → ignored; sweep result and timing unchanged. `start` held high throughout → second sweep begins one cycle after `done`, and `sig` is cleared before re-accumulating.
